ram_data_adapter: RTL and testbench
===================================

RAM_DATA_ADAPTER -- requirements
Module: ram_data_adapter

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 513, number of 32-bit words behind RAM port2.
REQ-002 SHALL have parameter TIMEOUT, default 15, max cycles waited for ram2_ack_i (range 1..15).
REQ-003 One clock; reset is asynchronous and active-low: sys_clk  in  1  rising-edge clock.
REQ-004 sys_rst_n  in  1  asynchronous active-low reset.
REQ-005 core_stb_i  in  1  data-side request strobe.
REQ-006 core_we_i  in  1  1 = write, 0 = read.
REQ-007 core_sel_i  in  4  byte enables; bit n selects data[8n+7:8n].
REQ-008 core_addr_i  in  18  byte address; word address = core_addr_i[17:2], bits [1:0] ignored.
REQ-009 core_data_i  in  32  write data.
REQ-010 core_ack_o  out  1  one-cycle completion pulse.
REQ-011 core_err_o  out  1  one-cycle error pulse.
REQ-012 core_data_o  out  32  read data, valid with core_ack_o.
REQ-013 core_busy_o  out  1  high while a request is in flight.
REQ-014 ram2_stb_o / ram2_we_o  out  1 / 1  RAM port2 strobe and write enable.
REQ-015 ram2_addr_o  out  16  RAM port2 word address.
REQ-016 ram2_data_o  out  32  RAM port2 write data.
REQ-017 ram2_data_i  in  32  RAM port2 read data; ram2_ack_i  in  1  RAM port2 read acknowledge.

Function
REQ-018 SHALL accept a request when core_stb_i=1 and state=IDLE, latching we, sel, word address and data in that cycle (cycle T).
REQ-019 core_busy_o SHALL equal (state != IDLE); core_stb_i is ignored while busy.
REQ-020 FSM states: IDLE, RD, RD_WAIT, WR, ACK, ERR.
REQ-021 IDLE -> ERR when latched word address >= RAM_WORDS; no RAM access is issued.
REQ-022 IDLE -> ACK for write with sel=4'h0 (no RAM access).
REQ-023 IDLE -> WR for write with sel=4'hF; IDLE -> RD for read or partial write (sel not 0, not F).
REQ-024 RD: ram2_stb_o=1, ram2_we_o=0 for exactly one cycle, then -> RD_WAIT.
REQ-025 RD_WAIT: on ram2_ack_i=1 capture ram2_data_i; read -> ACK, partial write -> WR.
REQ-026 RD_WAIT: timeout counter cleared on entry; if TIMEOUT cycles elapse without ram2_ack_i -> ERR.
REQ-027 WR: ram2_stb_o=1, ram2_we_o=1 for exactly one cycle with merged data, then -> ACK; no ack is awaited for writes.
REQ-028 Merge: byte n = core_data_i byte n if sel[n], else captured RAM byte n; full write uses core_data_i unchanged.
REQ-029 ACK: core_ack_o=1 one cycle -> IDLE; ERR: core_err_o=1 one cycle -> IDLE; never both high.
REQ-030 Latency from accept T: full write ack at T+2; read ack at T+3 with zero-wait RAM; partial write ack at T+4; range error err at T+1.
REQ-031 core_data_o SHALL update only on read completion and hold otherwise; writes leave it unchanged.
REQ-032 ram2_addr_o SHALL hold the latched word address while busy; ram2_stb_o=0 in IDLE, ACK, ERR, RD_WAIT.
REQ-033 Back-to-back: next request accepted in the IDLE cycle following ACK/ERR.

Reset
REQ-034 sys_rst_n=0 SHALL asynchronously force state=IDLE, counter=0, all outputs 0 (core_data_o=32'h0), including mid-operation; an aborted RMW issues no write.

Structure
REQ-035 State encoding and RAM_WORDS/TIMEOUT defaults SHALL live in shared package mem_commutator_pkg.
REQ-036 Byte merge SHALL be sub-module ram_byte_merge (combinational, sel/new/old -> merged).

Verification
REQ-037 Full write addr 18'h0010 data 32'hDEADBEEF sel F, then read 18'h0010 -> ack at T+2, read ack at T+3 with 32'hDEADBEEF.
REQ-038 Word 4 = 32'h11223344; write sel 4'b0101 data 32'hAABBCCDD; read -> 32'h11BB33DD, write ack at T+4.
REQ-039 Read byte addr 18'h00804 (word 513) -> core_err_o at T+1, no ram2_stb_o pulse.
REQ-040 RAM model withholds ram2_ack_i -> core_err_o after 15 RD_WAIT cycles, then IDLE and new request accepted.
REQ-041 Assert sys_rst_n=0 during RD_WAIT of partial write -> outputs 0 immediately, no ram2_we_o pulse, next request served normally.
REQ-042 core_stb_i held high for 10 cycles with sel=4'h0 write -> ack every 2 cycles, zero RAM strobes.

Source files
------------

// File: rtl/mem_commutator_pkg.sv
// Shared definitions for the RAM data adapter: FSM encoding, default
// geometry and timeout, and the word-address range test.
package mem_commutator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD      = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_WR      = 3'd3,
        ST_ACK     = 3'd4,
        ST_ERR     = 3'd5
    } state_t;

    localparam int         DEF_RAM_WORDS = 513;
    localparam int         DEF_TIMEOUT   = 15;
    localparam logic [3:0] SEL_NONE      = 4'h0;
    localparam logic [3:0] SEL_ALL       = 4'hF;

    // True when the word address lies inside the RAM behind port2.
    function automatic logic word_in_range(input logic [15:0] waddr, input int words);
        return {16'h0, waddr} < words;
    endfunction

endpackage

// File: rtl/ram_byte_merge.sv
// Byte-lane merge for read-modify-write: enabled lanes take the new data,
// the rest keep the word read back from RAM.
module ram_byte_merge (
    input  logic [3:0]  sel,
    input  logic [31:0] new_data,
    input  logic [31:0] old_data,
    output logic [31:0] merged
);

    // Select each byte lane independently from new or old data.
    always_comb begin
        merged = old_data;
        for (int n = 0; n < 4; n++) begin
            if (sel[n]) begin
                merged[8*n +: 8] = new_data[8*n +: 8];
            end
        end
    end

endmodule

// File: rtl/ram_data_adapter.sv
// Data-side bridge from a byte-enabled core request onto a word-wide RAM
// port. Partial writes become read-modify-write; reads wait for the RAM
// acknowledge with a bounded timeout.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for core_stb_i; request latched on acceptance
// ST_RD      | one-cycle read strobe on port2
// ST_RD_WAIT | waiting for ram2_ack_i, bounded by TIMEOUT cycles
// ST_WR      | one-cycle write strobe with full or merged data
// ST_ACK     | one-cycle completion pulse to the core
// ST_ERR     | one-cycle error pulse (range error or read timeout)
module ram_data_adapter
    import mem_commutator_pkg::*;
#(
    parameter int RAM_WORDS = DEF_RAM_WORDS,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        core_stb_i,
    input  logic        core_we_i,
    input  logic [3:0]  core_sel_i,
    input  logic [17:0] core_addr_i,
    input  logic [31:0] core_data_i,
    output logic        core_ack_o,
    output logic        core_err_o,
    output logic [31:0] core_data_o,
    output logic        core_busy_o,
    output logic        ram2_stb_o,
    output logic        ram2_we_o,
    output logic [15:0] ram2_addr_o,
    output logic [31:0] ram2_data_o,
    input  logic [31:0] ram2_data_i,
    input  logic        ram2_ack_i
);

    state_t      state;
    logic [3:0]  tmo_cnt;
    logic        we_q;
    logic [3:0]  sel_q;
    logic [31:0] data_q;
    logic [31:0] merged;
    logic        addr_ok;
    logic        unused_addr_bits;

    // Byte offset within the word has no meaning on a word-wide port.
    assign unused_addr_bits = ^core_addr_i[1:0];

    assign addr_ok     = word_in_range(core_addr_i[17:2], RAM_WORDS);
    assign core_busy_o = (state != ST_IDLE);

    ram_byte_merge u_merge (
        .sel      (sel_q),
        .new_data (data_q),
        .old_data (ram2_data_i),
        .merged   (merged)
    );

    // Request sequencing; every output is registered alongside the state.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            data_q      <= '0;
            core_ack_o  <= 1'b0;
            core_err_o  <= 1'b0;
            core_data_o <= '0;
            ram2_stb_o  <= 1'b0;
            ram2_we_o   <= 1'b0;
            ram2_addr_o <= '0;
            ram2_data_o <= '0;
        end else begin
            core_ack_o <= 1'b0;
            core_err_o <= 1'b0;
            ram2_stb_o <= 1'b0;
            ram2_we_o  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (core_stb_i) begin
                        we_q        <= core_we_i;
                        sel_q       <= core_sel_i;
                        data_q      <= core_data_i;
                        ram2_addr_o <= core_addr_i[17:2];
                        tmo_cnt     <= '0;
                        if (!addr_ok) begin
                            state      <= ST_ERR;
                            core_err_o <= 1'b1;
                        end else if (core_we_i && core_sel_i == SEL_NONE) begin
                            state      <= ST_ACK;
                            core_ack_o <= 1'b1;
                        end else if (core_we_i && core_sel_i == SEL_ALL) begin
                            state       <= ST_WR;
                            ram2_stb_o  <= 1'b1;
                            ram2_we_o   <= 1'b1;
                            ram2_data_o <= core_data_i;
                        end else begin
                            // Reads and partial writes both start by fetching the word.
                            state      <= ST_RD;
                            ram2_stb_o <= 1'b1;
                        end
                    end
                end
                ST_RD: begin
                    state   <= ST_RD_WAIT;
                    tmo_cnt <= '0;
                end
                ST_RD_WAIT: begin
                    if (ram2_ack_i) begin
                        if (we_q) begin
                            state       <= ST_WR;
                            ram2_stb_o  <= 1'b1;
                            ram2_we_o   <= 1'b1;
                            ram2_data_o <= merged;
                        end else begin
                            state       <= ST_ACK;
                            core_ack_o  <= 1'b1;
                            core_data_o <= ram2_data_i;
                        end
                    end else if (tmo_cnt == 4'(TIMEOUT - 1)) begin
                        state      <= ST_ERR;
                        core_err_o <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 4'd1;
                    end
                end
                ST_WR: begin
                    state      <= ST_ACK;
                    core_ack_o <= 1'b1;
                end
                ST_ACK, ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_data_adapter.sv
// Bench for ram_data_adapter: a behavioural RAM on port2, a reference
// memory model that predicts completion cycles and data from the request
// rules, and a per-cycle compare process.
module tb_ram_data_adapter;

    localparam int RAM_WORDS = 513;
    localparam int TIMEOUT   = 15;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        core_stb_i;
    logic        core_we_i;
    logic [3:0]  core_sel_i;
    logic [17:0] core_addr_i;
    logic [31:0] core_data_i;
    logic        core_ack_o;
    logic        core_err_o;
    logic [31:0] core_data_o;
    logic        core_busy_o;
    logic        ram2_stb_o;
    logic        ram2_we_o;
    logic [15:0] ram2_addr_o;
    logic [31:0] ram2_data_o;
    logic [31:0] ram2_data_i;
    logic        ram2_ack_i;

    ram_data_adapter #(.RAM_WORDS(RAM_WORDS), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .core_stb_i  (core_stb_i),
        .core_we_i   (core_we_i),
        .core_sel_i  (core_sel_i),
        .core_addr_i (core_addr_i),
        .core_data_i (core_data_i),
        .core_ack_o  (core_ack_o),
        .core_err_o  (core_err_o),
        .core_data_o (core_data_o),
        .core_busy_o (core_busy_o),
        .ram2_stb_o  (ram2_stb_o),
        .ram2_we_o   (ram2_we_o),
        .ram2_addr_o (ram2_addr_o),
        .ram2_data_o (ram2_data_o),
        .ram2_data_i (ram2_data_i),
        .ram2_ack_i  (ram2_ack_i)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Expectations for the request in flight (cycle numbers, -1 = none).
    int          req_t = -1, resp_cyc = -1;
    int          exp_ack_cyc = -1, exp_err_cyc = -1;
    int          exp_rd_stb = -1, exp_wr_stb = -1;
    logic [31:0] exp_wr_data = '0;
    logic [15:0] exp_addr = '0;
    bit          exp_is_read = 0;
    logic [31:0] exp_read_val = '0;
    logic [31:0] exp_rdata = '0;
    bit          in_reset = 1;

    int last_ack_cyc = -1, last_err_cyc = -1;
    int ack_count = 0, stb_count = 0, wr_count = 0;

    // RAM model controls and storage.
    int          ack_delay = 0;
    bit          ram_withhold = 0;
    logic [31:0] ram_mem [0:RAM_WORDS-1];
    logic [31:0] ref_mem [0:RAM_WORDS-1];
    bit          ram_init_done = 0;
    bit          rd_pend = 0;
    int          rd_wait = 0;
    logic [15:0] rd_addr = '0;

    function automatic logic [31:0] pattern(input int i);
        return 32'h5A5A_0000 ^ (32'(i) * 32'h0001_0003);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Port2 RAM: writes land on the strobe edge; reads acknowledge after ack_delay cycles.
    always @(posedge sys_clk) begin
        ram2_ack_i <= 1'b0;
        if (!ram_init_done) begin
            for (int i = 0; i < RAM_WORDS; i++) ram_mem[i] <= pattern(i);
            ram_init_done <= 1;
        end
        if (!sys_rst_n) begin
            rd_pend <= 0;
        end else if (ram2_stb_o && ram2_we_o) begin
            if (int'(ram2_addr_o) < RAM_WORDS) ram_mem[ram2_addr_o] <= ram2_data_o;
        end else if (ram2_stb_o) begin
            if (ack_delay == 0 && !ram_withhold) begin
                ram2_ack_i  <= 1'b1;
                ram2_data_i <= ram_mem[ram2_addr_o];
            end else begin
                rd_pend <= 1;
                rd_wait <= ack_delay - 1;
                rd_addr <= ram2_addr_o;
            end
        end else if (rd_pend && !ram_withhold) begin
            if (rd_wait <= 0) begin
                ram2_ack_i  <= 1'b1;
                ram2_data_i <= ram_mem[rd_addr];
                rd_pend     <= 0;
            end else begin
                rd_wait <= rd_wait - 1;
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model's schedule.
    always @(negedge sys_clk) begin
        bit busy_exp;
        if (ram2_stb_o) stb_count++;
        if (ram2_stb_o && ram2_we_o) wr_count++;
        if (!in_reset) begin
            if (cyc == exp_ack_cyc && exp_is_read) exp_rdata = exp_read_val;
            busy_exp = (cyc > req_t) && (cyc <= resp_cyc);
            check("core_ack", 32'(core_ack_o), 32'(cyc == exp_ack_cyc));
            check("core_err", 32'(core_err_o), 32'(cyc == exp_err_cyc));
            check("core_busy", 32'(core_busy_o), 32'(busy_exp));
            check("core_data", core_data_o, exp_rdata);
            check("ram2_stb", 32'(ram2_stb_o), 32'(cyc == exp_rd_stb || cyc == exp_wr_stb));
            if (cyc == exp_rd_stb || cyc == exp_wr_stb)
                check("ram2_we", 32'(ram2_we_o), 32'(cyc == exp_wr_stb));
            if (cyc == exp_wr_stb) check("ram2_data", ram2_data_o, exp_wr_data);
            if (busy_exp) check("ram2_addr", 32'(ram2_addr_o), 32'(exp_addr));
            if (core_ack_o) begin
                ack_count++;
                last_ack_cyc = cyc;
            end
            if (core_err_o) last_err_cyc = cyc;
        end
    end

    // Issue one request at the current negedge, predict its outcome from the
    // latency/merge rules, and return at the negedge after its completion.
    task automatic request(input bit we, input logic [3:0] sel, input logic [17:0] addr,
                           input logic [31:0] data, input bit keep, input int dly, input bit hold);
        int          w;
        int          t;
        int          rd_cyc;
        logic [31:0] m;
        w            = int'(addr[17:2]);
        ack_delay    = dly;
        ram_withhold = hold;
        core_stb_i   = 1'b1;
        core_we_i    = we;
        core_sel_i   = sel;
        core_addr_i  = addr;
        core_data_i  = data;
        t            = cyc;
        exp_ack_cyc  = -1;
        exp_err_cyc  = -1;
        exp_rd_stb   = -1;
        exp_wr_stb   = -1;
        exp_is_read  = 0;
        exp_addr     = addr[17:2];
        if (w >= RAM_WORDS) begin
            exp_err_cyc = t + 1;
        end else if (we && sel == 4'h0) begin
            exp_ack_cyc = t + 1;
        end else if (we && sel == 4'hF) begin
            exp_wr_stb  = t + 1;
            exp_wr_data = data;
            exp_ack_cyc = t + 2;
            ref_mem[w]  = data;
        end else begin
            exp_rd_stb = t + 1;
            if (hold) begin
                exp_err_cyc = t + 2 + TIMEOUT;
            end else begin
                rd_cyc = t + 2 + dly;
                if (!we) begin
                    exp_is_read  = 1;
                    exp_read_val = ref_mem[w];
                    exp_ack_cyc  = rd_cyc + 1;
                end else begin
                    m = ref_mem[w];
                    for (int n = 0; n < 4; n++) if (sel[n]) m[8*n +: 8] = data[8*n +: 8];
                    exp_wr_stb  = rd_cyc + 1;
                    exp_wr_data = m;
                    exp_ack_cyc = rd_cyc + 2;
                    ref_mem[w]  = m;
                end
            end
        end
        resp_cyc = (exp_ack_cyc > exp_err_cyc) ? exp_ack_cyc : exp_err_cyc;
        req_t    = t;
        @(negedge sys_clk);
        if (!keep) core_stb_i = 1'b0;
        while (cyc <= resp_cyc) @(negedge sys_clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " core_ack"}, 32'(core_ack_o), 32'h0);
        check({tag, " core_err"}, 32'(core_err_o), 32'h0);
        check({tag, " core_data"}, core_data_o, 32'h0);
        check({tag, " core_busy"}, 32'(core_busy_o), 32'h0);
        check({tag, " ram2_stb"}, 32'(ram2_stb_o), 32'h0);
        check({tag, " ram2_we"}, 32'(ram2_we_o), 32'h0);
        check({tag, " ram2_addr"}, 32'(ram2_addr_o), 32'h0);
        check({tag, " ram2_data"}, ram2_data_o, 32'h0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          stb_before, wr_before, acks_before, t0;
        logic [31:0] old_word;
        for (int i = 0; i < RAM_WORDS; i++) ref_mem[i] = pattern(i);
        sys_rst_n   = 1'b0;
        core_stb_i  = 1'b0;
        core_we_i   = 1'b0;
        core_sel_i  = 4'h0;
        core_addr_i = '0;
        core_data_i = '0;
        repeat (3) @(posedge sys_clk);
        #1 check_all_zero("reset");
        @(posedge sys_clk);
        #2 sys_rst_n = 1'b1;
        in_reset = 0;
        @(negedge sys_clk);
        @(negedge sys_clk);

        // Full write then read back, word 4.
        request(1, 4'hF, 18'h00010, 32'hDEADBEEF, 0, 0, 0);
        check("full write latency", 32'(last_ack_cyc - req_t), 32'd2);
        request(0, 4'hF, 18'h00010, 32'h0, 0, 0, 0);
        check("read latency", 32'(last_ack_cyc - req_t), 32'd3);
        check("read data DEADBEEF", core_data_o, 32'hDEADBEEF);

        // Read-modify-write with lanes 0 and 2.
        request(1, 4'hF, 18'h00010, 32'h11223344, 0, 0, 0);
        request(1, 4'b0101, 18'h00010, 32'hAABBCCDD, 0, 0, 0);
        check("partial write latency", 32'(last_ack_cyc - req_t), 32'd4);
        check("write keeps core_data", core_data_o, 32'hDEADBEEF);
        request(0, 4'h1, 18'h00013, 32'h0, 0, 0, 0);
        check("merged read 11BB33DD", core_data_o, 32'h11BB33DD);

        // Slower RAM, other lanes, last valid word, empty write.
        request(1, 4'b1000, 18'h00020, 32'h77665544, 0, 2, 0);
        request(1, 4'b0110, 18'h00020, 32'h0F0E0D0C, 0, 1, 0);
        request(0, 4'hF, 18'h00020, 32'h0, 0, 3, 0);
        request(0, 4'hF, 18'h00800, 32'h0, 0, 0, 0);
        check("last word read", core_data_o, pattern(512));
        request(1, 4'h0, 18'h00014, 32'hCAFEF00D, 0, 0, 0);

        // Range errors issue no RAM traffic.
        stb_before = stb_count;
        request(0, 4'hF, 18'h00804, 32'h0, 0, 0, 0);
        check("range error latency", 32'(last_err_cyc - req_t), 32'd1);
        request(1, 4'hF, 18'h3FFFC, 32'h12345678, 0, 0, 0);
        check("range error no strobe", 32'(stb_count - stb_before), 32'd0);

        // Withheld acknowledge times out, then a normal read is served.
        request(0, 4'hF, 18'h00030, 32'h0, 0, 0, 1);
        check("timeout err latency", 32'(last_err_cyc - req_t), 32'd17);
        request(0, 4'hF, 18'h00030, 32'h0, 0, 0, 0);
        check("read after timeout", core_data_o, pattern(12));

        // Reset while a partial write waits for its read data.
        wr_before   = wr_count;
        old_word    = ref_mem[4];
        ram_withhold = 1;
        core_stb_i  = 1'b1;
        core_we_i   = 1'b1;
        core_sel_i  = 4'b0011;
        core_addr_i = 18'h00010;
        core_data_i = 32'h99999999;
        exp_ack_cyc = -1;
        exp_err_cyc = -1;
        exp_wr_stb  = -1;
        exp_is_read = 0;
        exp_addr    = 16'h0004;
        exp_rd_stb  = cyc + 1;
        resp_cyc    = cyc + 1000;
        req_t       = cyc;
        @(negedge sys_clk);
        core_stb_i = 1'b0;
        repeat (3) @(negedge sys_clk);
        #2;
        in_reset  = 1;
        sys_rst_n = 1'b0;
        #1 check_all_zero("mid-op reset");
        repeat (3) @(posedge sys_clk);
        check("no write after reset", 32'(wr_count - wr_before), 32'd0);
        check("ram word intact", ram_mem[4], old_word);
        req_t        = -1;
        resp_cyc     = -1;
        exp_rd_stb   = -1;
        exp_rdata    = '0;
        ram_withhold = 0;
        #2 sys_rst_n = 1'b1;
        in_reset = 0;
        @(negedge sys_clk);
        request(0, 4'hF, 18'h00010, 32'h0, 0, 0, 0);
        check("read after reset", core_data_o, 32'h11BB33DD);

        // Strobe held high with empty writes: one ack every two cycles.
        acks_before = ack_count;
        stb_before  = stb_count;
        t0          = cyc;
        for (int i = 0; i < 5; i++) request(1, 4'h0, 18'h00040, 32'(i), 1, 0, 0);
        core_stb_i = 1'b0;
        check("held strobe ack count", 32'(ack_count - acks_before), 32'd5);
        check("held strobe no ram", 32'(stb_count - stb_before), 32'd0);
        check("held strobe duration", 32'(cyc - t0), 32'd10);

        repeat (3) @(negedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
